// File: rtl/calc_mp_core.sv
// Multi-port calculator core: per-port two-cycle request capture, per-port request FIFOs,
// one shared ALU served round-robin, and a registered result on the issuing port's lane.
module calc_mp_core #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_WIDTH  = 4,
    parameter int RESP_WIDTH = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS*CMD_WIDTH-1:0]   req_cmd_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data_in,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS*RESP_WIDTH-1:0]  out_resp,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  out_data
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int EW = CMD_WIDTH + 2 * DATA_WIDTH;

    localparam logic [CMD_WIDTH-1:0]  CMD_ADD  = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0]  CMD_SUB  = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0]  CMD_SHL  = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0]  CMD_SHR  = CMD_WIDTH'(6);
    localparam logic [RESP_WIDTH-1:0] RESP_OK  = RESP_WIDTH'(1);
    localparam logic [RESP_WIDTH-1:0] RESP_ERR = RESP_WIDTH'(2);

    logic [EW-1:0]          w_head [NUM_PORTS];
    logic [NUM_PORTS-1:0]   w_not_empty;
    logic [NUM_PORTS-1:0]   w_pop;
    logic                   w_grant_valid;
    logic [PW-1:0]          w_grant_idx;
    logic [PW-1:0]          w_cand;
    logic [PW-1:0]          r_ptr;
    int                     w_idx;

    logic [EW-1:0]          w_sel;
    logic [CMD_WIDTH-1:0]   w_sel_cmd;
    logic [DATA_WIDTH-1:0]  w_sel_op1;
    logic [DATA_WIDTH-1:0]  w_sel_op2;
    logic [DATA_WIDTH:0]    w_sum;
    logic [RESP_WIDTH-1:0]  w_alu_resp;
    logic [DATA_WIDTH-1:0]  w_alu_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [CMD_WIDTH-1:0]  w_cmd;
            logic [DATA_WIDTH-1:0] w_data;
            logic                  w_accept;
            logic [CW:0]           w_occupancy;
            logic                  r_cap_valid;
            logic [CMD_WIDTH-1:0]  r_cap_cmd;
            logic [DATA_WIDTH-1:0] r_cap_op1;
            logic [EW-1:0]         r_mem [FIFO_DEPTH];
            logic [AW-1:0]         r_wr_ptr;
            logic [AW-1:0]         r_rd_ptr;
            logic [CW-1:0]         r_count;
            logic [RESP_WIDTH-1:0] r_resp;
            logic [DATA_WIDTH-1:0] r_data;

            assign w_cmd  = req_cmd_in[gi*CMD_WIDTH +: CMD_WIDTH];
            assign w_data = req_data_in[gi*DATA_WIDTH +: DATA_WIDTH];

            // A request waiting for its op2 already owns a FIFO slot.
            assign w_occupancy    = {1'b0, r_count} + {{CW{1'b0}}, r_cap_valid};
            assign req_ready[gi]  = !rst && (w_occupancy < (CW+1)'(FIFO_DEPTH));
            // A cmd arriving in the op2 cycle is a protocol violation and is ignored.
            assign w_accept       = req_ready[gi] && (w_cmd != '0) && !r_cap_valid;
            assign w_not_empty[gi] = (r_count != '0);
            assign w_head[gi]     = r_mem[r_rd_ptr];
            assign w_pop[gi]      = w_grant_valid && (w_grant_idx == PW'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cap_valid <= 1'b0;
                    r_cap_cmd   <= '0;
                    r_cap_op1   <= '0;
                end else begin
                    r_cap_valid <= w_accept;
                    if (w_accept) begin
                        r_cap_cmd <= w_cmd;
                        r_cap_op1 <= w_data;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (r_cap_valid) begin
                    r_mem[r_wr_ptr] <= {r_cap_cmd, r_cap_op1, w_data};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (r_cap_valid) begin
                        r_wr_ptr <= (r_wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
                    end
                    if (w_pop[gi]) begin
                        r_rd_ptr <= (r_rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
                    end
                    case ({r_cap_valid, w_pop[gi]})
                        2'b10:   r_count <= r_count + CW'(1);
                        2'b01:   r_count <= r_count - CW'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_resp <= '0;
                    r_data <= '0;
                end else if (w_pop[gi]) begin
                    r_resp <= w_alu_resp;
                    r_data <= w_alu_data;
                end else begin
                    r_resp <= '0;
                    r_data <= '0;
                end
            end

            assign out_resp[gi*RESP_WIDTH +: RESP_WIDTH] = r_resp;
            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_data;
        end
    endgenerate

    // Round-robin search starting at r_ptr; first non-empty FIFO wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_idx         = 0;
        w_cand        = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NUM_PORTS) begin
                w_idx = w_idx - NUM_PORTS;
            end
            w_cand = PW'(w_idx);
            if (!w_grant_valid && w_not_empty[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant_valid) begin
            r_ptr <= (w_grant_idx == PW'(NUM_PORTS - 1)) ? '0 : w_grant_idx + PW'(1);
        end
    end

    assign w_sel     = w_head[w_grant_idx];
    assign w_sel_cmd = w_sel[EW-1 -: CMD_WIDTH];
    assign w_sel_op1 = w_sel[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign w_sel_op2 = w_sel[DATA_WIDTH-1:0];

    always_comb begin
        w_alu_resp = RESP_ERR;
        w_alu_data = '0;
        w_sum      = {1'b0, w_sel_op1} + {1'b0, w_sel_op2};
        case (w_sel_cmd)
            CMD_ADD: begin
                if (!w_sum[DATA_WIDTH]) begin
                    w_alu_resp = RESP_OK;
                    w_alu_data = w_sum[DATA_WIDTH-1:0];
                end
            end
            CMD_SUB: begin
                if (w_sel_op1 >= w_sel_op2) begin
                    w_alu_resp = RESP_OK;
                    w_alu_data = w_sel_op1 - w_sel_op2;
                end
            end
            CMD_SHL: begin
                w_alu_resp = RESP_OK;
                w_alu_data = w_sel_op1 << w_sel_op2[SW-1:0];
            end
            CMD_SHR: begin
                w_alu_resp = RESP_OK;
                w_alu_data = w_sel_op1 >> w_sel_op2[SW-1:0];
            end
            default: begin
                w_alu_resp = RESP_ERR;
                w_alu_data = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_mp_core.sv
// Bench for calc_mp_core: directed scenarios plus random multi-port traffic, checked every
// cycle against a queue-based transaction model of ports, FIFOs and round-robin service.
`timescale 1ns/1ps
module tb_calc_mp_core;

    localparam int NP    = 4;
    localparam int DW    = 32;
    localparam int CW    = 4;
    localparam int RW    = 2;
    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NP*CW-1:0]    req_cmd_in;
    logic [NP*DW-1:0]    req_data_in;
    logic [NP-1:0]       req_ready;
    logic [NP*RW-1:0]    out_resp;
    logic [NP*DW-1:0]    out_data;

    always #5 clk = ~clk;

    calc_mp_core #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DW),
        .CMD_WIDTH (CW),
        .RESP_WIDTH(RW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_cmd_in (req_cmd_in),
        .req_data_in(req_data_in),
        .req_ready  (req_ready),
        .out_resp   (out_resp),
        .out_data   (out_data)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    req_t        m_q [NP][$];
    logic        m_cap_v [NP];
    logic [3:0]  m_cap_cmd [NP];
    logic [31:0] m_cap_a [NP];
    int          m_ptr;
    logic [1:0]  m_exp_resp [NP];
    logic [31:0] m_exp_data [NP];

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_acc = 0;
    int   n_resp_dut = 0;
    logic port3_drop_seen = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void alu_ref(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                    output logic [1:0] r, output logic [31:0] d);
        logic [63:0] s;
        r = 2'd2;
        d = 32'd0;
        case (cmd)
            4'd1: begin
                s = 64'(a) + 64'(b);
                if (s < 64'h1_0000_0000) begin
                    r = 2'd1;
                    d = s[31:0];
                end
            end
            4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = a << (b % 32); end
            4'd6: begin r = 2'd1; d = a >> (b % 32); end
            default: begin r = 2'd2; d = 32'd0; end
        endcase
    endfunction

    function automatic logic model_ready(input int p);
        return (m_q[p].size() + (m_cap_v[p] ? 1 : 0)) < DEPTH;
    endfunction

    // One clock of the transaction model: service, then op2 completion, then new captures.
    function automatic void model_step(input logic r, input logic [NP*CW-1:0] c, input logic [NP*DW-1:0] d);
        logic rdy [NP];
        logic was_cap [NP];
        int   g;
        req_t e;
        for (int p = 0; p < NP; p++) begin
            m_exp_resp[p] = 2'd0;
            m_exp_data[p] = 32'd0;
        end
        if (r) begin
            for (int p = 0; p < NP; p++) begin
                m_q[p].delete();
                m_cap_v[p] = 1'b0;
            end
            m_ptr = 0;
            return;
        end
        for (int p = 0; p < NP; p++) begin
            rdy[p]     = model_ready(p);
            was_cap[p] = m_cap_v[p];
        end
        g = -1;
        for (int i = 0; i < NP; i++) begin
            if (g < 0 && m_q[(m_ptr + i) % NP].size() > 0) g = (m_ptr + i) % NP;
        end
        if (g >= 0) begin
            e = m_q[g].pop_front();
            alu_ref(e.cmd, e.a, e.b, m_exp_resp[g], m_exp_data[g]);
            m_ptr = (g + 1) % NP;
        end
        for (int p = 0; p < NP; p++) begin
            if (was_cap[p]) begin
                e.cmd = m_cap_cmd[p];
                e.a   = m_cap_a[p];
                e.b   = d[p*DW +: DW];
                m_q[p].push_back(e);
                m_cap_v[p] = 1'b0;
            end
            if (c[p*CW +: CW] != 4'd0 && rdy[p] && !was_cap[p]) begin
                m_cap_v[p]   = 1'b1;
                m_cap_cmd[p] = c[p*CW +: CW];
                m_cap_a[p]   = d[p*DW +: DW];
                n_acc++;
            end
        end
    endfunction

    task automatic check_outputs(input logic r, input logic [NP*CW-1:0] c);
        logic [NP-1:0] exp_rdy;
        for (int p = 0; p < NP; p++) begin
            exp_rdy[p] = !r && model_ready(p);
            check_eq($sformatf("resp%0d", p), 64'(out_resp[p*RW +: RW]), 64'(m_exp_resp[p]));
            check_eq($sformatf("data%0d", p), 64'(out_data[p*DW +: DW]), 64'(m_exp_data[p]));
            if (out_resp[p*RW +: RW] != 2'd0) n_resp_dut++;
        end
        check_eq("ready", 64'(req_ready), 64'(exp_rdy));
        if (!r && !req_ready[3] && c[3*CW +: CW] != 4'd0) port3_drop_seen = 1'b1;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic do_cycle(input logic r, input logic [NP*CW-1:0] c, input logic [NP*DW-1:0] d);
        rst         = r;
        req_cmd_in  = c;
        req_data_in = d;
        #1;
        check_outputs(r, c);
        @(posedge clk);
        model_step(r, c, d);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        repeat (n) do_cycle(1'b0, '0, '0);
    endtask

    task automatic issue_and_check(input int p, input logic [3:0] cmd, input logic [31:0] a,
                                   input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed,
                                   input string tag);
        logic [NP*CW-1:0] c;
        logic [NP*DW-1:0] d;
        c = '0; d = '0;
        c[p*CW +: CW] = cmd;
        d[p*DW +: DW] = a;
        do_cycle(1'b0, c, d);
        c = '0; d = '0;
        d[p*DW +: DW] = b;
        do_cycle(1'b0, c, d);
        do_cycle(1'b0, '0, '0);
        check_eq({tag, "_resp"}, 64'(out_resp[p*RW +: RW]), 64'(er));
        check_eq({tag, "_data"}, 64'(out_data[p*DW +: DW]), 64'(ed));
    endtask

    function automatic logic [3:0] rand_cmd();
        case ($urandom_range(0, 11))
            0, 1, 2: return 4'd1;
            3, 4, 5: return 4'd2;
            6, 7:    return 4'd5;
            8, 9:    return 4'd6;
            10:      return 4'd3;
            default: return 4'($urandom_range(7, 15));
        endcase
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 40));
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Protocol-following traffic; cmds are issued regardless of req_ready.
    task automatic traffic(input int ncyc, input int pct, input int rst_pm);
        logic        ph [NP];
        logic [31:0] op2 [NP];
        logic [NP*CW-1:0] c;
        logic [NP*DW-1:0] d;
        logic r;
        for (int p = 0; p < NP; p++) ph[p] = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            c = '0; d = '0; r = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (ph[p]) begin
                    d[p*DW +: DW] = op2[p];
                    ph[p] = 1'b0;
                end else if (int'($urandom_range(0, 99)) < pct) begin
                    c[p*CW +: CW] = rand_cmd();
                    d[p*DW +: DW] = rand_op();
                    op2[p] = rand_op();
                    ph[p] = 1'b1;
                end else begin
                    d[p*DW +: DW] = $urandom;
                end
            end
            if (rst_pm > 0 && int'($urandom_range(0, 999)) < rst_pm) r = 1'b1;
            do_cycle(r, c, d);
        end
    endtask

    task automatic all_ports_add(input int o0, input int o1, input int o2, input int o3, input string tag);
        logic [NP*CW-1:0] c;
        logic [NP*DW-1:0] d;
        int ord [NP];
        int g;
        ord[0] = o0; ord[1] = o1; ord[2] = o2; ord[3] = o3;
        c = '0; d = '0;
        for (int p = 0; p < NP; p++) begin
            c[p*CW +: CW] = 4'd1;
            d[p*DW +: DW] = 32'(p);
        end
        do_cycle(1'b0, c, d);
        c = '0;
        do_cycle(1'b0, c, d);
        do_cycle(1'b0, '0, '0);
        for (int k = 0; k < NP; k++) begin
            g = ord[k];
            check_eq($sformatf("%s_k%0d_resp", tag, k), 64'(out_resp[g*RW +: RW]), 64'd1);
            check_eq($sformatf("%s_k%0d_data", tag, k), 64'(out_data[g*DW +: DW]), 64'(2 * g));
            do_cycle(1'b0, '0, '0);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_cmd_in = '0;
        req_data_in = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        model_step(1'b1, '0, '0);
        do_cycle(1'b1, '0, '0);
        do_cycle(1'b1, '0, '0);

        rst = 1'b0;
        req_cmd_in = '0;
        #1;
        check_eq("ready_after_reset", 64'(req_ready), 64'hF);

        issue_and_check(0, 4'd1, 32'd5, 32'd7, 2'd1, 32'd12, "add_5_7");
        drain(2);

        issue_and_check(1, 4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2, 32'd0, "add_ovf");
        issue_and_check(1, 4'd2, 32'd3, 32'd5, 2'd2, 32'd0, "sub_neg");
        issue_and_check(1, 4'd2, 32'd5, 32'd3, 2'd1, 32'd2, "sub_ok");
        drain(2);

        do_cycle(1'b1, '0, '0);
        all_ports_add(0, 1, 2, 3, "rr_ptr0");
        issue_and_check(1, 4'd1, 32'd0, 32'd0, 2'd1, 32'd0, "set_ptr2");
        drain(2);
        all_ports_add(2, 3, 0, 1, "rr_ptr2");

        n_acc = 0;
        n_resp_dut = 0;
        port3_drop_seen = 1'b0;
        traffic(60, 100, 0);
        drain(30);
        check_eq("stream_resp_count", 64'(n_resp_dut), 64'(n_acc));
        check_eq("port3_drop_seen", 64'(port3_drop_seen), 64'd1);

        issue_and_check(0, 4'd5, 32'd1, 32'd33, 2'd1, 32'd2, "shl_33");
        issue_and_check(3, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'd1, "shr_31");
        issue_and_check(2, 4'd4, 32'd9, 32'd9, 2'd2, 32'd0, "cmd_invalid");
        drain(2);

        traffic(20, 100, 0);
        do_cycle(1'b1, {NP{4'd1}}, {NP{32'd3}});
        rst = 1'b0;
        req_cmd_in = '0;
        #1;
        check_eq("ready_after_midreset", 64'(req_ready), 64'hF);
        n_resp_dut = 0;
        issue_and_check(2, 4'd1, 32'd1, 32'd1, 2'd1, 32'd2, "post_rst_add");
        drain(20);
        check_eq("post_rst_resp_count", 64'(n_resp_dut), 64'd1);

        traffic(2500, 40, 3);
        drain(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
